// File: rtl/zero_priority_alloc_if.sv
// Request/grant and status bundle for the zero-priority slot allocator.
// The master side issues alloc/release requests; the slave side is the allocator.
interface zero_priority_alloc_if #(
    parameter int WIDTH = 16
);
    localparam int IDXW = $clog2(WIDTH) + 1;

    logic            alloc_req;
    logic            alloc_gnt;
    logic [IDXW-1:0] alloc_idx;
    logic            rel_valid;
    logic [IDXW-1:0] rel_idx;
    logic [WIDTH-1:0] busy_map;
    logic [IDXW-1:0] free_cnt;
    logic            full;
    logic            empty;
    logic            err;

    modport master (
        output alloc_req, rel_valid, rel_idx,
        input  alloc_gnt, alloc_idx, busy_map, free_cnt, full, empty, err
    );

    modport slave (
        input  alloc_req, rel_valid, rel_idx,
        output alloc_gnt, alloc_idx, busy_map, free_cnt, full, empty, err
    );
endinterface

// File: rtl/zero_priority_alloc.sv
// Slot allocator: registered busy map, first-free grant via a zero-priority
// encoder, release by index with error pulse on bad releases.
module zero_priority_alloc #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    zero_priority_alloc_if.slave bus
);
    localparam int IDXW = $clog2(WIDTH) + 1;
    localparam logic [IDXW-1:0] NONE = IDXW'(WIDTH);

    logic [WIDTH-1:0] busy_q, busy_d, gnt_mask, rel_mask;
    logic [IDXW-1:0]  cnt_q, cnt_d, idx_q, enc;
    logic             gnt_q, err_q, gnt_c, rel_ok, full_c;

    // Scan order is fixed at elaboration; the last free slot seen in the loop wins.
    generate
        if (LSB_FIRST) begin : g_lsb
            always_comb begin
                enc = NONE;
                for (int i = WIDTH - 1; i >= 0; i--)
                    if (!busy_q[i]) enc = IDXW'(i);
            end
        end else begin : g_msb
            always_comb begin
                enc = NONE;
                for (int i = 0; i < WIDTH; i++)
                    if (!busy_q[i]) enc = IDXW'(i);
            end
        end
    endgenerate

    assign full_c   = (cnt_q == '0);
    assign gnt_c    = bus.alloc_req && !full_c;
    assign gnt_mask = gnt_c ? (WIDTH'(1) << enc) : '0;
    // An out-of-range index shifts out to zero, so it can never match a busy bit.
    assign rel_mask = bus.rel_valid ? (WIDTH'(1) << bus.rel_idx) : '0;
    assign rel_ok   = |(rel_mask & busy_q);

    // Grant comes from the pre-release map, so the two masks never overlap.
    assign busy_d = (busy_q | gnt_mask) & ~(rel_ok ? rel_mask : '0);
    assign cnt_d  = cnt_q - IDXW'(gnt_c) + IDXW'(rel_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= NONE;
            gnt_q  <= 1'b0;
            idx_q  <= NONE;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            gnt_q  <= gnt_c;
            idx_q  <= gnt_c ? enc : NONE;
            err_q  <= bus.rel_valid && !rel_ok;
        end
    end

    assign bus.busy_map  = busy_q;
    assign bus.free_cnt  = cnt_q;
    assign bus.alloc_gnt = gnt_q;
    assign bus.alloc_idx = idx_q;
    assign bus.err       = err_q;
    assign bus.full      = full_c;
    assign bus.empty     = (cnt_q == NONE);

    a_cnt_consistent: assert property (@(posedge clk) disable iff (rst)
        int'(cnt_q) == WIDTH - $countones(busy_q));
endmodule

// File: tb/tb_zero_priority_alloc.sv
// Randomized + directed bench for zero_priority_alloc against a slot-array model.
module tb_zero_priority_alloc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    zero_priority_alloc_if #(.WIDTH(16)) if0 ();
    zero_priority_alloc_if #(.WIDTH(16)) if1 ();
    zero_priority_alloc_if #(.WIDTH(5))  if2 ();

    zero_priority_alloc #(.WIDTH(16), .LSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    zero_priority_alloc #(.WIDTH(16), .LSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    zero_priority_alloc #(.WIDTH(5),  .LSB_FIRST(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int total = 0;
    int bad   = 0;

    // Model: one bit per slot per instance, plus each instance's width and scan order.
    bit mbusy [3][16];
    int mw    [3] = '{16, 16, 5};
    bit mlsb  [3] = '{1'b1, 1'b0, 1'b1};
    int e_gnt, e_idx, e_err;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(int d, bit req, bit rv, int ridx);
        case (d)
            0: begin if0.alloc_req = req; if0.rel_valid = rv; if0.rel_idx = 5'(ridx); end
            1: begin if1.alloc_req = req; if1.rel_valid = rv; if1.rel_idx = 5'(ridx); end
            default: begin if2.alloc_req = req; if2.rel_valid = rv; if2.rel_idx = 4'(ridx); end
        endcase
    endtask

    function automatic int mfree(int d);
        int n = 0;
        for (int i = 0; i < mw[d]; i++) if (!mbusy[d][i]) n++;
        return n;
    endfunction

    function automatic int mmap(int d);
        int m = 0;
        for (int i = 0; i < mw[d]; i++) if (mbusy[d][i]) m |= (1 << i);
        return m;
    endfunction

    function automatic int mfirst(int d);
        if (mlsb[d]) begin
            for (int i = 0; i < mw[d]; i++) if (!mbusy[d][i]) return i;
        end else begin
            for (int i = mw[d] - 1; i >= 0; i--) if (!mbusy[d][i]) return i;
        end
        return mw[d];
    endfunction

    task automatic check(int d, string tag);
        logic [31:0] g, ix, er, mp, fc, fu, em;
        case (d)
            0: begin g = 32'(if0.alloc_gnt); ix = 32'(if0.alloc_idx); er = 32'(if0.err);
                     mp = 32'(if0.busy_map); fc = 32'(if0.free_cnt); fu = 32'(if0.full); em = 32'(if0.empty); end
            1: begin g = 32'(if1.alloc_gnt); ix = 32'(if1.alloc_idx); er = 32'(if1.err);
                     mp = 32'(if1.busy_map); fc = 32'(if1.free_cnt); fu = 32'(if1.full); em = 32'(if1.empty); end
            default: begin g = 32'(if2.alloc_gnt); ix = 32'(if2.alloc_idx); er = 32'(if2.err);
                     mp = 32'(if2.busy_map); fc = 32'(if2.free_cnt); fu = 32'(if2.full); em = 32'(if2.empty); end
        endcase
        chk({tag, ".gnt"}, g, e_gnt);
        chk({tag, ".idx"}, ix, e_idx);
        chk({tag, ".err"}, er, e_err);
        chk({tag, ".map"}, mp, mmap(d));
        chk({tag, ".free"}, fc, mfree(d));
        chk({tag, ".full"}, fu, 32'(mfree(d) == 0));
        chk({tag, ".empty"}, em, 32'(mfree(d) == mw[d]));
    endtask

    // One clock of traffic on instance d, model updated from the pre-edge state.
    task automatic step(int d, bit req, bit rv, int ridx, string tag);
        bit g, ok;
        drive(d, req, rv, ridx);
        g  = req && (mfree(d) > 0);
        ok = 1'b0;
        if (rv && ridx >= 0 && ridx < mw[d]) ok = mbusy[d][ridx];
        e_gnt = g;
        e_idx = g ? mfirst(d) : mw[d];
        e_err = rv && !ok;
        @(posedge clk); #1;
        if (g)  mbusy[d][e_idx] = 1'b1;
        if (ok) mbusy[d][ridx]  = 1'b0;
        drive(d, 1'b0, 1'b0, 0);
        check(d, tag);
    endtask

    // Reset is shared, so every instance and its model are cleared together.
    task automatic do_reset(int d, bit req);
        rst = 1'b1;
        drive(d, req, 1'b0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(d, 1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) mbusy[k][i] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e_gnt = 0; e_idx = mw[k]; e_err = 0;
            check(k, "reset");
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 0);

        // fill all 16 slots, then one refused request
        do_reset(0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b1, 1'b0, 0, "t1_fill");
            chk("t1_seq_idx", 32'(if0.alloc_idx), i);
        end
        chk("t1_full", 32'(if0.full), 1);
        step(0, 1'b1, 1'b0, 0, "t1_req17");
        chk("t1_req17_idx", 32'(if0.alloc_idx), 16);

        // release 5 and 9, re-allocate in ascending order
        step(0, 1'b0, 1'b1, 5, "t2_rel5");
        step(0, 1'b0, 1'b1, 9, "t2_rel9");
        step(0, 1'b1, 1'b0, 0, "t2_alloc_a");
        chk("t2_idx5", 32'(if0.alloc_idx), 5);
        step(0, 1'b1, 1'b0, 0, "t2_alloc_b");
        chk("t2_idx9", 32'(if0.alloc_idx), 9);

        // full map: simultaneous alloc+release refuses the grant
        step(0, 1'b1, 1'b1, 3, "t4_both");
        chk("t4_free1", 32'(if0.free_cnt), 1);
        step(0, 1'b1, 1'b0, 0, "t4_next");
        chk("t4_idx3", 32'(if0.alloc_idx), 3);
        chk("t4_free0", 32'(if0.free_cnt), 0);

        // bad releases
        step(0, 1'b0, 1'b1, 7, "t5_rel7");
        step(0, 1'b0, 1'b1, 7, "t5_rel7_again");
        chk("t5_err_free", 32'(if0.err), 1);
        step(0, 1'b0, 1'b1, 20, "t5_rel20");
        chk("t5_err_range", 32'(if0.err), 1);

        // reset wins over a pending request
        do_reset(0, 1'b0);
        for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b0, 0, "t6_fill");
        chk("t6_map", 32'(if0.busy_map), 32'h00FF);
        do_reset(0, 1'b1);

        // highest-first scan order
        do_reset(1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1'b1, 1'b0, 0, "t3_msb");
            chk("t3_msb_idx", 32'(if1.alloc_idx), 15 - i);
        end

        // WIDTH=5 build
        do_reset(2, 1'b0);
        for (int i = 0; i < 5; i++) step(2, 1'b1, 1'b0, 0, "t7_w5");
        chk("t7_w5_full", 32'(if2.full), 1);
        step(2, 1'b1, 1'b0, 0, "t7_w5_over");

        // random traffic on each instance
        for (int d = 0; d < 3; d++) begin
            do_reset(d, 1'b0);
            for (int n = 0; n < 400; n++)
                step(d, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
                     int'($urandom_range(0, mw[d] + 3)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
